// File: rtl/limbus_i2s_pkg.sv
// -----------------------------------------------------------------------------
// limbus_i2s_pkg
// Shared types and constants for the acortex I2S master transmitter:
//   - tx_state_e    : transmitter FSM encoding (IDLE, RUN, DRAIN)
//   - FRAME_SLOTS   : BCLK periods per stereo frame at the default sample width
//   - LRCK_LEFT/RIGHT : word-select encoding (0 = left, 1 = right)
//   - lrck_for_slot : word-select level for a slot. It is right-channel one slot
//                     early, so that LRCK leads the MSB by one BCLK.
// -----------------------------------------------------------------------------
package limbus_i2s_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } tx_state_e;

    localparam int SAMPLE_WIDTH_DEF = 16;
    localparam int FRAME_SLOTS      = 2 * SAMPLE_WIDTH_DEF;

    localparam logic LRCK_LEFT  = 1'b0;
    localparam logic LRCK_RIGHT = 1'b1;

    // Right-channel select covers slots sw-1 .. 2*sw-2. It leads the data by one BCLK.
    function automatic logic lrck_for_slot(input int slot, input int sw);
        if ((slot >= (sw - 32'sd1)) && (slot <= ((32'sd2 * sw) - 32'sd2))) begin
            lrck_for_slot = LRCK_RIGHT;
        end else begin
            lrck_for_slot = LRCK_LEFT;
        end
    endfunction

endpackage

// File: rtl/limbus_i2s_bclk_gen.sv
// -----------------------------------------------------------------------------
// limbus_i2s_bclk_gen
// Bit-clock divider for the I2S transmitter.
// The divider counts 0..BCLK_DIV-1 while run is high. At terminal count it
// wraps, and the registered bclk output toggles. While run is low, both the
// divider and bclk are held at 0. A new run therefore always starts with a
// full low half-period.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   run        : divider enable
//   bclk       : registered bit clock
//   fall_evt   : strobe on the clk edge where bclk toggles 1 -> 0
//   rise_evt   : strobe on the clk edge where bclk toggles 0 -> 1
// -----------------------------------------------------------------------------
module limbus_i2s_bclk_gen #(
    parameter int BCLK_DIV  = 4,
    parameter int DIV_WIDTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic bclk,
    output logic fall_evt,
    output logic rise_evt
);

    localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(BCLK_DIV - 1);

    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] div_d;
    logic                 bclk_q;
    logic                 bclk_d;
    logic                 term_cnt;

    // Divider next-state and bclk toggle decision.
    always_comb begin
        term_cnt = run && (div_q == DIV_LAST);
        if (!run) begin
            div_d  = '0;
            bclk_d = 1'b0;
        end else if (term_cnt) begin
            div_d  = '0;
            bclk_d = ~bclk_q;
        end else begin
            div_d  = div_q + DIV_WIDTH'(1);
            bclk_d = bclk_q;
        end
    end

    // Divider and bclk registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q  <= '0;
            bclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            bclk_q <= bclk_d;
        end
    end

    assign bclk     = bclk_q;
    assign fall_evt = term_cnt & bclk_q;
    assign rise_evt = term_cnt & ~bclk_q;

endmodule

// File: rtl/limbus_sys_acortex_i2s_tx.sv
// -----------------------------------------------------------------------------
// limbus_sys_acortex_i2s_tx
// This block is an Avalon-ST sink that drives an I2S master transmitter. It is
// the consumer end of the acortex timing-adaptor FIFO. One stereo word
// ([31:16] left, [15:0] right) is taken into a one-word holding register. At
// every frame start, that word moves to the shift register, and the shift
// register is sent MSB first. Data and LRCK change only on BCLK falling edges,
// and the codec samples them on the rising edge.
// Ports:
//   clk, reset      : system clock, synchronous active-high reset
//   tx_en           : transmitter enable. Dropping it finishes the current frame.
//   in_ready/in_valid/in_data : stream sink, ready latency 0
//   i2s_bclk, i2s_lrck, i2s_sdata : I2S master outputs
//   underflow       : one-clk pulse when a frame starts with no word held
//   busy            : high while frames are being generated
// Optional (macro LIMBUS_I2S_TX_UNDERFLOW_CNT_EN):
//   underflow_clr   : clears the underflow counter. It wins over an increment.
//   underflow_cnt   : saturating 16-bit count of underflow pulses
// DATA_WIDTH must equal 2*SAMPLE_WIDTH.
// -----------------------------------------------------------------------------
module limbus_sys_acortex_i2s_tx
    import limbus_i2s_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int BCLK_DIV     = 4,
    parameter int DIV_WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tx_en,
    output logic                  in_ready,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  i2s_bclk,
    output logic                  i2s_lrck,
    output logic                  i2s_sdata,
    output logic                  underflow,
    output logic                  busy
`ifdef LIMBUS_I2S_TX_UNDERFLOW_CNT_EN
    ,
    input  logic                  underflow_clr,
    output logic [15:0]           underflow_cnt
`endif
);

    localparam int                SLOTS     = 2 * SAMPLE_WIDTH;
    localparam int                SLOT_W    = $clog2(SLOTS);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);

    tx_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_valid_q, hold_valid_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic                  lrck_q, lrck_d;
    logic                  sdata_q, sdata_d;
    logic                  underflow_q, underflow_d;
    logic                  busy_q, busy_d;

    logic                  xfer;
    logic                  hold_take;
    logic                  bclk_run;
    logic                  bclk_fall;
    // The rise strobe is not used here. The codec samples on that edge.
    logic                  bclk_rise_unused;

    assign bclk_run = (state_q != ST_IDLE);

    limbus_i2s_bclk_gen #(
        .BCLK_DIV  (BCLK_DIV),
        .DIV_WIDTH (DIV_WIDTH)
    ) u_bclk_gen (
        .clk      (clk),
        .reset    (reset),
        .run      (bclk_run),
        .bclk     (i2s_bclk),
        .fall_evt (bclk_fall),
        .rise_evt (bclk_rise_unused)
    );

    // Ready is combinational because the interface has ready latency 0. It is
    // forced low during reset.
    assign in_ready = tx_en & ~hold_valid_q & ~reset;
    assign xfer     = in_valid & in_ready;

    // FSM next-state, frame load, shift and holding-register update.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        shift_d      = shift_q;
        slot_d       = slot_q;
        lrck_d       = lrck_q;
        sdata_d      = sdata_q;
        underflow_d  = 1'b0;
        hold_take    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                shift_d = '0;
                lrck_d  = LRCK_LEFT;
                sdata_d = 1'b0;
                if (tx_en) begin
                    // Start one slot before the frame, so the first fall loads slot 0.
                    state_d = ST_RUN;
                    slot_d  = SLOT_LAST;
                end else begin
                    state_d = ST_IDLE;
                    slot_d  = '0;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (bclk_fall) begin
                    if (slot_q == SLOT_LAST) begin
                        slot_d = '0;
                        if (state_q == ST_DRAIN) begin
                            shift_d = '0;
                        end else if (hold_valid_q) begin
                            shift_d   = hold_q;
                            hold_take = 1'b1;
                        end else begin
                            shift_d     = '0;
                            underflow_d = 1'b1;
                        end
                    end else begin
                        slot_d  = slot_q + SLOT_W'(1);
                        shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
                    end
                    sdata_d = shift_d[DATA_WIDTH-1];
                    lrck_d  = lrck_for_slot(int'(slot_d), SAMPLE_WIDTH);
                end else begin
                    slot_d  = slot_q;
                    shift_d = shift_q;
                end

                if (state_q == ST_DRAIN) begin
                    if (bclk_fall && (slot_q == SLOT_LAST)) begin
                        state_d = ST_IDLE;
                        lrck_d  = LRCK_LEFT;
                        sdata_d = 1'b0;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else if (!tx_en) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                shift_d = '0;
                slot_d  = '0;
                lrck_d  = LRCK_LEFT;
                sdata_d = 1'b0;
            end
        endcase

        // A capture can only happen when hold is empty, so it never collides
        // with a load that takes the held word.
        if (xfer) begin
            hold_d       = in_data;
            hold_valid_d = 1'b1;
        end else if (hold_take) begin
            hold_valid_d = 1'b0;
        end else begin
            hold_valid_d = hold_valid_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            shift_q      <= '0;
            slot_q       <= '0;
            lrck_q       <= 1'b0;
            sdata_q      <= 1'b0;
            underflow_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            shift_q      <= shift_d;
            slot_q       <= slot_d;
            lrck_q       <= lrck_d;
            sdata_q      <= sdata_d;
            underflow_q  <= underflow_d;
            busy_q       <= busy_d;
        end
    end

    assign i2s_lrck  = lrck_q;
    assign i2s_sdata = sdata_q;
    assign underflow = underflow_q;
    assign busy      = busy_q;

`ifdef LIMBUS_I2S_TX_UNDERFLOW_CNT_EN
    logic [15:0] ucnt_q, ucnt_d;

    // Saturating underflow counter. A clear wins over an increment.
    always_comb begin
        if (underflow_clr) begin
            ucnt_d = 16'h0000;
        end else if (underflow_d && (ucnt_q != 16'hFFFF)) begin
            ucnt_d = ucnt_q + 16'h0001;
        end else begin
            ucnt_d = ucnt_q;
        end
    end

    // Underflow counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ucnt_q <= 16'h0000;
        end else begin
            ucnt_q <= ucnt_d;
        end
    end

    assign underflow_cnt = ucnt_q;
`endif

endmodule
